// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per result unit, round-robin
// pick of one full buffer per cycle, registered broadcast onto the CDB.
module cdb_arbiter #(
   parameter int N_SRC  = 4,
   parameter int ROB_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [N_SRC-1:0]           req_valid,
   input  logic [N_SRC*ROB_W-1:0]     req_dest_rob,
   input  logic [N_SRC*DATA_W-1:0]    req_value,
   output logic [N_SRC-1:0]           req_ready,
   output logic                       cdb_valid,
   output logic [ROB_W-1:0]           cdb_dest_rob,
   output logic [DATA_W-1:0]          cdb_value,
   output logic [$clog2(N_SRC)-1:0]   cdb_src
);

   localparam int SRC_W = $clog2(N_SRC);

   logic [N_SRC-1:0]  buf_valid_r;
   logic [ROB_W-1:0]  buf_rob_r [N_SRC];
   logic [DATA_W-1:0] buf_val_r [N_SRC];
   logic [SRC_W-1:0]  rr_ptr_r;

   logic              cdb_valid_r;
   logic [ROB_W-1:0]  cdb_dest_rob_r;
   logic [DATA_W-1:0] cdb_value_r;
   logic [SRC_W-1:0]  cdb_src_r;

   logic [N_SRC-1:0]  grant_s;
   logic              any_grant_s;
   logic [SRC_W-1:0]  win_idx_s;
   logic [SRC_W-1:0]  ptr_next_s;
   logic [N_SRC-1:0]  req_ready_s;
   logic [N_SRC-1:0]  load_s;

   // Round-robin search over buffer state only, starting at rr_ptr_r.
   always_comb begin
      logic [SRC_W:0]   sum_v;
      logic [SRC_W:0]   wrap_v;
      logic [SRC_W-1:0] idx_v;
      logic             take_v;
      grant_s     = '0;
      any_grant_s = 1'b0;
      win_idx_s   = '0;
      sum_v       = '0;
      wrap_v      = '0;
      idx_v       = '0;
      take_v      = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         sum_v          = {1'b0, rr_ptr_r} + (SRC_W+1)'(k);
         wrap_v         = (sum_v >= (SRC_W+1)'(N_SRC)) ? (sum_v - (SRC_W+1)'(N_SRC)) : sum_v;
         idx_v          = wrap_v[SRC_W-1:0];
         take_v         = ~any_grant_s & buf_valid_r[idx_v];
         grant_s[idx_v] = grant_s[idx_v] | take_v;
         win_idx_s      = take_v ? idx_v : win_idx_s;
         any_grant_s    = any_grant_s | take_v;
      end
   end

   // Pointer advance and per-source handshake; a granted buffer may be refilled in the same cycle.
   always_comb begin
      ptr_next_s  = (win_idx_s == SRC_W'(N_SRC-1)) ? '0 : (win_idx_s + SRC_W'(1));
      req_ready_s = {N_SRC{rst & ~flush}} & (~buf_valid_r | grant_s);
      load_s      = req_valid & req_ready_s;
   end

   // Holding buffers: load on handshake, clear when drained, drop everything on flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_valid_r <= '0;
         for (int i = 0; i < N_SRC; i++) begin
            buf_rob_r[i] <= '0;
            buf_val_r[i] <= '0;
         end
      end else if (flush) begin
         buf_valid_r <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (load_s[i]) begin
               buf_valid_r[i] <= 1'b1;
               buf_rob_r[i]   <= req_dest_rob[i*ROB_W +: ROB_W];
               buf_val_r[i]   <= req_value[i*DATA_W +: DATA_W];
            end else if (grant_s[i]) begin
               buf_valid_r[i] <= 1'b0;
            end
         end
      end
   end

   // CDB broadcast register and round-robin pointer; payload holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_r       <= '0;
         cdb_valid_r    <= 1'b0;
         cdb_dest_rob_r <= '0;
         cdb_value_r    <= '0;
         cdb_src_r      <= '0;
      end else if (flush) begin
         cdb_valid_r <= 1'b0;
      end else if (any_grant_s) begin
         cdb_valid_r    <= 1'b1;
         cdb_dest_rob_r <= buf_rob_r[win_idx_s];
         cdb_value_r    <= buf_val_r[win_idx_s];
         cdb_src_r      <= win_idx_s;
         rr_ptr_r       <= ptr_next_s;
      end else begin
         cdb_valid_r <= 1'b0;
      end
   end

   assign req_ready    = req_ready_s;
   assign cdb_valid    = cdb_valid_r;
   assign cdb_dest_rob = cdb_dest_rob_r;
   assign cdb_value    = cdb_value_r;
   assign cdb_src      = cdb_src_r;

endmodule
